lpc_reg_arbiter: RTL and testbench
==================================

Name: lpc_reg_arbiter

Overview:
- Shares the single register-bank port between two masters.
  - The LPC slave side: fixed-latency, cannot be stalled, absolute priority.
  - One internal master (e.g. the BIOS watchdog or LED sequencer) using a req/ack handshake.
- Tracks LPC bus activity from LpcFrame and opens a protected window per LPC cycle.
- Grants the internal master only outside that window.
- Sits between the LPC slave block and the register bank (LpcRegs/LpcMux).

Parameters:
- LPC_WINDOW, 14: clocks the LPC side owns the port after each LpcFrame low sample (START through TAR plus margin).
- CNT_W, 4: width of the window counter; must hold LPC_WINDOW.
- STARVE_LIMIT, 255: cycles an internal request may pend before IntStarve is raised.
- STARVE_W, 8: width of the starvation counter.

Ports:
- LpcClock  in  1  33 MHz LPC clock; all state on rising edge.
- PciReset  in  1  asynchronous, active-low reset.
- LpcFrame  in  1  LPC frame, active low.
- LpcAddr  in  8  register address from the LPC slave.
- LpcWr  in  1  one-clock LPC write strobe.
- LpcDataWr  in  8  LPC write data.
- LpcDataRd  out  8  read data to the LPC slave; combinational copy of RegRData.
- IntReq  in  1  internal request, level; held with IntWe/IntAddr/IntWData stable until IntAck.
- IntWe  in  1  1 = write, 0 = read.
- IntAddr  in  8  internal address.
- IntWData  in  8  internal write data.
- IntAck  out  1  one-clock completion pulse.
- IntRData  out  8  captured read data; valid from IntAck onward, held until the next internal read.
- IntStarve  out  1  sticky starvation flag; cleared by the next successful grant.
- RegAddr  out  8  register-bank address.
- RegWe  out  1  register-bank write enable.
- RegWData  out  8  register-bank write data.
- RegRData  in  8  register-bank read data (asynchronous read).
- LpcBusy  out  1  high while state is LPC_BUSY.

Behaviour:
- Reset (PciReset low, asynchronous): state IDLE, window counter 0, starve counter 0.
  - Outputs: IntAck 0, IntRData 0x00, IntStarve 0, LpcBusy 0.
  - RegWe is 0 because it is driven only by LpcWr or an INT_ACC cycle.
- Reset mid-access aborts the access with no ack. The master must keep IntReq high and is re-arbitrated after reset.
- States:
  - IDLE
    - LpcFrame==0 -> LPC_BUSY, counter <= LPC_WINDOW.
    - Else if IntReq==1 and IntAck==0 -> INT_ACC.
    - LpcFrame has priority when both occur in the same cycle.
  - LPC_BUSY
    - Any LpcFrame==0 reloads the counter to LPC_WINDOW; otherwise the counter decrements.
    - Counter==1 with LpcFrame high -> IDLE on the next edge.
    - IntReq is ignored throughout.
  - INT_ACC (exactly 1 clock)
    - Port is driven from the internal master.
    - Read: IntRData <= RegRData at the end of the cycle.
    - IntAck pulses on the following cycle.
    - Next state: LPC_BUSY if LpcFrame==0 this cycle (counter loaded), else IDLE.
- Port mux, combinational:
  - Priority order: LpcWr==1 -> LPC; state==INT_ACC -> internal; otherwise -> LPC.
  - The LPC default path means the read address always follows LpcAddr, with zero added latency.
  - RegWe = LpcWr | (INT_ACC & IntWe & ~LpcWr).
- Collision: LpcWr==1 during INT_ACC.
  - LPC write wins.
  - Internal access is dropped: no capture, no IntAck.
  - Next state is LPC_BUSY with counter <= LPC_WINDOW.
  - Request is retried once the window closes.
- LpcWr outside LPC_BUSY (stray strobe) is always honoured on the port. No state change except via the collision rule above.
- IntAck is ignored as a new request in the cycle it is high. This guarantees at least one IDLE cycle between back-to-back internal accesses.
- Starvation:
  - Counter increments each cycle IntReq==1 and state!=INT_ACC.
  - It saturates at STARVE_LIMIT; reaching the limit sets IntStarve.
  - Counter clears on IntAck or when IntReq==0.
  - IntStarve clears on IntAck.
- Back-to-back LPC cycles keep reloading the window, so the internal master can starve; this is by design and flagged by IntStarve.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, LPC_BUSY=2'd1, INT_ACC=2'd2) and the LPC_WINDOW default, next to the existing BAR define.
- One natural sub-module, lpc_window_timer: the reloadable down-counter. Inputs: load, LpcFrame. Output: window-active.
- Mux and FSM stay in the top.

Test Plan:
- Internal read, bus idle: IntReq=1, IntWe=0, IntAddr=0x12, RegRData=0xA5 -> INT_ACC one clock later with RegAddr=0x12, RegWe=0; IntAck pulse next clock; IntRData=0xA5.
- LPC write: LpcFrame low 1 clk, LpcWr pulse at clk 7 with LpcAddr=0x30, LpcDataWr=0x5A -> RegWe=1, RegAddr=0x30, RegWData=0x5A that clock; LpcBusy high 14 clocks after the last LpcFrame low.
- Request during window: IntReq raised at clk 3 of an LPC cycle -> no INT_ACC until LpcBusy falls; IntAck exactly 2 clocks after LpcBusy falls.
- Collision: force LpcWr=1 during INT_ACC with IntWe=1 -> RegWData=LpcDataWr, no IntAck; internal write completes after the next window closes.
- Starvation: IntReq held while LpcFrame pulses every 10 clocks for 300 clocks -> IntStarve=1 at pending cycle 255; stop LPC -> IntAck, IntStarve clears.
- Async reset during INT_ACC: PciReset low -> all outputs 0 immediately, no IntAck; after release with IntReq still high -> access reissued and acked.

Source files
------------

// File: rtl/lpc_reg_arbiter_pkg.sv
// Shared types and defaults for the LPC / internal-master register port arbiter.
package lpc_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LPC_BUSY = 2'd1,
    INT_ACC  = 2'd2
  } arb_state_e;

  localparam int LPC_WINDOW_DEF   = 14;
  localparam int CNT_W_DEF        = 4;
  localparam int STARVE_LIMIT_DEF = 255;
  localparam int STARVE_W_DEF     = 8;

endpackage

// File: rtl/lpc_reg_arbiter_window_timer.sv
// Reloadable down-counter that holds the LPC protected window open after each LpcFrame low.
module lpc_window_timer
  import lpc_reg_arbiter_pkg::*;
#(
  parameter int LPC_WINDOW = LPC_WINDOW_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_lpc_frame,
  output logic o_active
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_reload;

  assign w_reload = i_load | ~i_lpc_frame;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_reload) begin
      r_cnt <= CNT_W'(LPC_WINDOW);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Active means the window is still open after the coming edge.
  assign o_active = w_reload | (r_cnt > CNT_W'(1));

endmodule

// File: rtl/lpc_reg_arbiter.sv
// Register-bank port arbiter: LPC slave has absolute priority, internal master gets idle gaps.
//   state    | meaning
//   IDLE     | port follows LPC, internal request may be granted
//   LPC_BUSY | LPC protected window open, internal requests held off
//   INT_ACC  | one-clock internal access on the port
module lpc_reg_arbiter
  import lpc_reg_arbiter_pkg::*;
#(
  parameter int LPC_WINDOW   = LPC_WINDOW_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int STARVE_W     = STARVE_W_DEF
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LpcFrame,
  input  logic [7:0] LpcAddr,
  input  logic       LpcWr,
  input  logic [7:0] LpcDataWr,
  output logic [7:0] LpcDataRd,
  input  logic       IntReq,
  input  logic       IntWe,
  input  logic [7:0] IntAddr,
  input  logic [7:0] IntWData,
  output logic       IntAck,
  output logic [7:0] IntRData,
  output logic       IntStarve,
  output logic [7:0] RegAddr,
  output logic       RegWe,
  output logic [7:0] RegWData,
  input  logic [7:0] RegRData,
  output logic       LpcBusy
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic                w_win_active;
  logic                w_collide;
  logic                w_lpc_sel;
  logic                r_ack;
  logic [7:0]          r_rdata;
  logic                r_starve;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_starve_cnt_nxt;

  assign w_collide = (r_state == INT_ACC) & LpcWr;

  lpc_window_timer #(
    .LPC_WINDOW (LPC_WINDOW),
    .CNT_W      (CNT_W)
  ) u_window_timer (
    .i_clk       (LpcClock),
    .i_rst_n     (PciReset),
    .i_load      (w_collide),
    .i_lpc_frame (LpcFrame),
    .o_active    (w_win_active)
  );

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!LpcFrame) begin
          w_state_nxt = LPC_BUSY;
        end else if (IntReq && !r_ack) begin
          w_state_nxt = INT_ACC;
        end
      end
      LPC_BUSY: begin
        if (!w_win_active) begin
          w_state_nxt = IDLE;
        end
      end
      INT_ACC: begin
        w_state_nxt = (!LpcFrame || LpcWr) ? LPC_BUSY : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A write strobe always takes the port, even mid internal access.
  always_comb begin
    LpcBusy   = (r_state == LPC_BUSY);
    w_lpc_sel = LpcWr | (r_state != INT_ACC);
    RegAddr   = w_lpc_sel ? LpcAddr   : IntAddr;
    RegWData  = w_lpc_sel ? LpcDataWr : IntWData;
    RegWe     = LpcWr | ((r_state == INT_ACC) & IntWe & ~LpcWr);
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_ack <= (r_state == INT_ACC) & ~LpcWr;
      if ((r_state == INT_ACC) && !IntWe && !LpcWr) begin
        r_rdata <= RegRData;
      end
    end
  end

  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (r_ack || !IntReq) begin
      w_starve_cnt_nxt = '0;
    end else if ((r_state != INT_ACC) && (r_starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
      w_starve_cnt_nxt = r_starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_cnt_nxt;
      if (r_ack) begin
        r_starve <= 1'b0;
      end else if (w_starve_cnt_nxt == STARVE_W'(STARVE_LIMIT)) begin
        r_starve <= 1'b1;
      end
    end
  end

  assign LpcDataRd = RegRData;
  assign IntAck    = r_ack;
  assign IntRData  = r_rdata;
  assign IntStarve = r_starve;

endmodule

// File: tb/tb_lpc_reg_arbiter.sv
// Directed bench for lpc_reg_arbiter with a behavioural register bank and a read-data scoreboard.
module tb_lpc_reg_arbiter;

  logic       LpcClock;
  logic       PciReset;
  logic       LpcFrame;
  logic [7:0] LpcAddr;
  logic       LpcWr;
  logic [7:0] LpcDataWr;
  logic [7:0] LpcDataRd;
  logic       IntReq;
  logic       IntWe;
  logic [7:0] IntAddr;
  logic [7:0] IntWData;
  logic       IntAck;
  logic [7:0] IntRData;
  logic       IntStarve;
  logic [7:0] RegAddr;
  logic       RegWe;
  logic [7:0] RegWData;
  logic [7:0] RegRData;
  logic       LpcBusy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  bit [7:0] mem   [256];
  bit       valid [256];

  lpc_reg_arbiter dut (
    .LpcClock  (LpcClock),
    .PciReset  (PciReset),
    .LpcFrame  (LpcFrame),
    .LpcAddr   (LpcAddr),
    .LpcWr     (LpcWr),
    .LpcDataWr (LpcDataWr),
    .LpcDataRd (LpcDataRd),
    .IntReq    (IntReq),
    .IntWe     (IntWe),
    .IntAddr   (IntAddr),
    .IntWData  (IntWData),
    .IntAck    (IntAck),
    .IntRData  (IntRData),
    .IntStarve (IntStarve),
    .RegAddr   (RegAddr),
    .RegWe     (RegWe),
    .RegWData  (RegWData),
    .RegRData  (RegRData),
    .LpcBusy   (LpcBusy)
  );

  initial LpcClock = 1'b0;
  always #5 LpcClock = ~LpcClock;

  // Unwritten locations read back as addr ^ 0xB7, so 0x12 reads 0xA5.
  function automatic logic [7:0] bank_rd(input logic [7:0] a);
    return valid[a] ? mem[a] : (a ^ 8'hB7);
  endfunction

  assign RegRData = bank_rd(RegAddr);

  always @(posedge LpcClock) begin
    if (RegWe) begin
      mem[RegAddr]   <= RegWData;
      valid[RegAddr] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge LpcClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed IntAck with empty scoreboard, expected no ack", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, {24'h0, IntRData}, {24'h0, e});
    end
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (IntAck !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_ack"}, {31'h0, IntAck}, 32'd1);
    if (IntAck === 1'b1) sb_pop(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  early;
    bit  acked;

    PciReset  = 1'b0;
    LpcFrame  = 1'b1;
    LpcAddr   = 8'h00;
    LpcWr     = 1'b0;
    LpcDataWr = 8'h00;
    IntReq    = 1'b0;
    IntWe     = 1'b0;
    IntAddr   = 8'h00;
    IntWData  = 8'h00;

    #3;
    check("rst_ack",    {31'h0, IntAck},    32'd0);
    check("rst_rdata",  {24'h0, IntRData},  32'h00);
    check("rst_starve", {31'h0, IntStarve}, 32'd0);
    check("rst_busy",   {31'h0, LpcBusy},   32'd0);
    check("rst_we",     {31'h0, RegWe},     32'd0);
    #20 PciReset = 1'b1;
    tick();

    // Internal read with the bus idle
    IntReq = 1'b1; IntWe = 1'b0; IntAddr = 8'h12;
    exp_q.push_back(8'hA5);
    tick();
    check("t1_acc_addr", {24'h0, RegAddr}, 32'h12);
    check("t1_acc_we",   {31'h0, RegWe},   32'd0);
    check("t1_acc_ack",  {31'h0, IntAck},  32'd0);
    tick();
    check("t1_ack", {31'h0, IntAck}, 32'd1);
    sb_pop("t1");
    IntReq = 1'b0;
    tick();
    check("t1_ack_pulse", {31'h0, IntAck}, 32'd0);

    // LPC window length after one LpcFrame low
    LpcFrame = 1'b0;
    tick();
    LpcFrame = 1'b1;
    n = 0;
    while (LpcBusy && n < 40) begin n++; tick(); end
    check("t2_busy_len", n, 32'd14);

    // LPC write at clk 7 of a cycle
    LpcFrame = 1'b0;
    tick();
    LpcFrame = 1'b1;
    repeat (5) tick();
    LpcWr = 1'b1; LpcAddr = 8'h30; LpcDataWr = 8'h5A;
    #1;
    check("t2_we",    {31'h0, RegWe},    32'd1);
    check("t2_addr",  {24'h0, RegAddr},  32'h30);
    check("t2_wdata", {24'h0, RegWData}, 32'h5A);
    tick();
    LpcWr = 1'b0; LpcAddr = 8'h00;
    n = 0;
    while (LpcBusy && n < 40) begin n++; tick(); end
    check("t2_busy_fell", {31'h0, LpcBusy}, 32'd0);

    // Request raised inside the window waits for it to close
    LpcFrame = 1'b0;
    tick();
    LpcFrame = 1'b1;
    tick();
    tick();
    IntReq = 1'b1; IntWe = 1'b0; IntAddr = 8'h30;
    exp_q.push_back(8'h5A);
    early = 1'b0;
    n = 0;
    while (LpcBusy && n < 40) begin
      tick();
      n++;
      if (IntAck || RegAddr == 8'h30) early = 1'b1;
    end
    check("t3_no_early_grant", {31'h0, early},   32'd0);
    check("t3_busy_fell",      {31'h0, LpcBusy}, 32'd0);
    tick();
    check("t3_acc_ack",  {31'h0, IntAck},  32'd0);
    check("t3_acc_addr", {24'h0, RegAddr}, 32'h30);
    tick();
    check("t3_ack_2clk", {31'h0, IntAck}, 32'd1);
    sb_pop("t3");
    IntReq = 1'b0;

    // Stray LPC write while idle
    tick();
    LpcWr = 1'b1; LpcAddr = 8'h60; LpcDataWr = 8'h3C;
    #1;
    check("t4_stray_we",    {31'h0, RegWe},    32'd1);
    check("t4_stray_wdata", {24'h0, RegWData}, 32'h3C);
    tick();
    LpcWr = 1'b0; LpcAddr = 8'h00;
    check("t4_stray_nobusy", {31'h0, LpcBusy}, 32'd0);
    IntReq = 1'b1; IntWe = 1'b0; IntAddr = 8'h60;
    exp_q.push_back(8'h3C);
    wait_ack("t4_readback");
    IntReq = 1'b0;
    tick();

    // Collision: LPC write during an internal write
    IntReq = 1'b1; IntWe = 1'b1; IntAddr = 8'h44; IntWData = 8'h77;
    LpcAddr = 8'h45; LpcDataWr = 8'h99;
    exp_q.push_back(8'h3C);
    tick();
    LpcWr = 1'b1;
    #1;
    check("t5_col_wdata", {24'h0, RegWData}, 32'h99);
    check("t5_col_addr",  {24'h0, RegAddr},  32'h45);
    check("t5_col_we",    {31'h0, RegWe},    32'd1);
    tick();
    LpcWr = 1'b0; LpcAddr = 8'h00;
    check("t5_col_noack", {31'h0, IntAck},  32'd0);
    check("t5_col_busy",  {31'h0, LpcBusy}, 32'd1);
    wait_ack("t5_retry");
    IntReq = 1'b0;
    check("t5_mem44", {24'h0, bank_rd(8'h44)}, 32'h77);
    check("t5_mem45", {24'h0, bank_rd(8'h45)}, 32'h99);
    tick();

    // Starvation under back-to-back LPC cycles
    LpcFrame = 1'b0;
    tick();
    LpcFrame = 1'b1;
    IntReq = 1'b1; IntWe = 1'b0; IntAddr = 8'h12;
    exp_q.push_back(8'hA5);
    acked = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (IntAck) acked = 1'b1;
      if (k == 254) check("t6_starve_254", {31'h0, IntStarve}, 32'd0);
      if (k == 255) check("t6_starve_255", {31'h0, IntStarve}, 32'd1);
      LpcFrame = ((k % 10) == 0 && k <= 290) ? 1'b0 : 1'b1;
    end
    check("t6_no_ack_starved", {31'h0, acked},     32'd0);
    check("t6_starve_held",    {31'h0, IntStarve}, 32'd1);
    wait_ack("t6");
    IntReq = 1'b0;
    tick();
    check("t6_starve_clr", {31'h0, IntStarve}, 32'd0);

    // Asynchronous reset during INT_ACC
    IntReq = 1'b1; IntWe = 1'b0; IntAddr = 8'h12;
    exp_q.push_back(8'hA5);
    tick();
    check("t7_acc_addr", {24'h0, RegAddr}, 32'h12);
    #2;
    PciReset = 1'b0;
    #1;
    check("t7_rst_ack",    {31'h0, IntAck},    32'd0);
    check("t7_rst_rdata",  {24'h0, IntRData},  32'h00);
    check("t7_rst_starve", {31'h0, IntStarve}, 32'd0);
    check("t7_rst_busy",   {31'h0, LpcBusy},   32'd0);
    check("t7_rst_we",     {31'h0, RegWe},     32'd0);
    check("t7_rst_addr",   {24'h0, RegAddr},   32'h00);
    tick();
    check("t7_rst_noack", {31'h0, IntAck}, 32'd0);
    PciReset = 1'b1;
    wait_ack("t7_reissue");
    IntReq = 1'b0;
    tick();

    check("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
